// File: rtl/scc_pkg.sv
// Shared fetch/decode definitions: address width, instruction word, HALT opcode fields, fetch FSM states.
// Pure declarations; no timing or flow control lives here.
package scc_pkg;

  localparam int ADDR_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;
  localparam int FIFO_DEPTH = 2;

  typedef logic [31:0] instr_t;

  localparam logic [1:0] OP_SYS_BRANCH = 2'b11;
  localparam logic [3:0] SYS_HALT      = 4'b1000;

  typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} fetch_state_e;

  typedef struct packed {
    instr_t            instr;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  function automatic logic is_halt(input instr_t w);
    return (w[31:30] == OP_SYS_BRANCH) && (w[28:25] == SYS_HALT);
  endfunction

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry fetch buffer with flush; head is a register, so it is stable while not popped.
// Push and pop may coincide; the caller's credit check keeps pushes off a full buffer.
module fetch_fifo2
  import scc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push_vld,
  input  logic [ENTRY_W-1:0] push_dat,
  input  logic               pop_vld,
  output logic               head_vld,
  output logic [ENTRY_W-1:0] head_dat,
  output logic [1:0]         occupancy
);

  logic [ENTRY_W-1:0] head_q, head_d;
  logic [ENTRY_W-1:0] tail_q, tail_d;
  logic [1:0]         cnt_q, cnt_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      unique case ({push_vld, pop_vld})
        2'b10: begin
          if (cnt_q == 2'd0) head_d = push_dat;
          else               tail_d = push_dat;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: new word either replaces a lone head or slides in behind it.
          if (cnt_q == 2'd1) begin
            head_d = push_dat;
          end else begin
            head_d = tail_q;
            tail_d = push_dat;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_vld  = (cnt_q != 2'd0);
  assign head_dat  = head_q;
  assign occupancy = cnt_q;

  no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_vld && !pop_vld && !flush && (cnt_q == 2'(FIFO_DEPTH))));

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, 1-cycle imem issue under a 2-credit window, redirect flush, HALT stop; 1 instr/cycle.
// Issue throttles when buffer + in-flight would exceed 2; if_instr/if_pc hold while ID stalls.
module instr_fetch
  import scc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              id_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;
  logic              epoch_q, epoch_d;
  logic              req_epoch_q, req_epoch_d;
  logic              halted_q, halted_d;

  logic              pop, push, redirect;
  logic [2:0]        credit_use;
  logic [1:0]        occupancy;
  logic [ENTRY_W-1:0] head_raw;
  fetch_entry_t      push_ent, head_ent;

  assign pop        = if_valid && id_ready;
  assign redirect   = redirect_valid && (state_q != HALTED);
  assign credit_use = {1'b0, occupancy} + {2'b00, inflight_q} - {2'b00, pop};
  assign imem_req   = rst_n && (state_q == RUN) && !redirect_valid && (credit_use < 3'd2);
  assign imem_addr  = pc_q;

  // A response is kept only if no redirect has bumped the epoch since it was issued,
  // and nothing is buffered once a HALT has gone in.
  assign push     = inflight_q && (req_epoch_q == epoch_q) && !redirect && (state_q == RUN);
  assign push_ent = '{instr: imem_rdata, pc: req_pc_q};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_epoch_d = req_epoch_q;
    epoch_d     = epoch_q;
    inflight_d  = imem_req;
    if (imem_req) begin
      pc_d        = pc_q + ADDR_W'(1);
      req_pc_d    = pc_q;
      req_epoch_d = epoch_q;
    end
    if (redirect) begin
      pc_d    = redirect_pc;
      epoch_d = !epoch_q;
    end
    unique case (state_q)
      RUN:       if (push && is_halt(imem_rdata)) state_d = HALT_PEND;
      HALT_PEND: begin
        if (pop && is_halt(head_ent.instr)) state_d = HALTED;
        else if (redirect)                  state_d = RUN;
      end
      default: ;
    endcase
    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      inflight_q  <= 1'b0;
      epoch_q     <= 1'b0;
      req_epoch_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      inflight_q  <= inflight_d;
      epoch_q     <= epoch_d;
      req_epoch_q <= req_epoch_d;
      halted_q    <= halted_d;
    end
  end

  fetch_fifo2 u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push_vld  (push),
    .push_dat  (push_ent),
    .pop_vld   (pop),
    .head_vld  (if_valid),
    .head_dat  (head_raw),
    .occupancy (occupancy)
  );

  assign head_ent = fetch_entry_t'(head_raw);
  assign if_instr = head_ent.instr;
  assign if_pc    = head_ent.pc;
  assign halted   = halted_q;

endmodule
